// File: rtl/lsm_decision_unit.sv
`default_nettype none
// ============================================================================
// lsm_decision_unit : Longstaff-Schwartz exercise decision, 4-stage pipeline.
// Optional saturating arithmetic: define LSM_DECISION_SAT_EN.  Rev 1.0
// ============================================================================
module lsm_decision_unit #(
    parameter int WIDTH = 32,
    parameter int QINT  = 16,
    parameter int QFRAC = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    output logic                    ready_out,
    input  logic signed [WIDTH-1:0] S_t,
    input  logic signed [WIDTH-1:0] beta [0:2],
    input  logic signed [WIDTH-1:0] strike,
    input  logic signed [WIDTH-1:0] disc,
    output logic                    valid_out,
    input  logic                    ready_in,
    output logic signed [WIDTH-1:0] PV
);

    localparam int c_PW = 2 * WIDTH;
    localparam logic signed [WIDTH-1:0] c_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] c_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] c_ZERO = '0;
`ifdef LSM_DECISION_SAT_EN
    localparam bit c_SAT_EN = 1'b1;
`else
    localparam bit c_SAT_EN = 1'b0;
`endif

    if (QINT + QFRAC != WIDTH) begin : g_qformat_check
        $error("lsm_decision_unit: QINT + QFRAC must equal WIDTH");
    end

    // Reduce a wide intermediate to WIDTH bits: wrap, or clip when saturation is built in.
    function automatic logic signed [WIDTH-1:0] narrow(input logic signed [c_PW-1:0] x);
        logic signed [WIDTH-1:0] lo;
        logic                    fits;
        lo   = x[WIDTH-1:0];
        fits = (x == c_PW'(lo));
        if (c_SAT_EN && !fits) begin
            return x[c_PW-1] ? c_MIN : c_MAX;
        end
        return lo;
    endfunction

    function automatic logic signed [WIDTH-1:0] fx_mul(input logic signed [WIDTH-1:0] a,
                                                       input logic signed [WIDTH-1:0] b);
        logic signed [c_PW-1:0] p;
        p = c_PW'(a) * c_PW'(b);
        return narrow(p >>> QFRAC);
    endfunction

    function automatic logic signed [WIDTH-1:0] fx_add(input logic signed [WIDTH-1:0] a,
                                                       input logic signed [WIDTH-1:0] b);
        logic signed [WIDTH:0] s;
        s = (WIDTH+1)'(a) + (WIDTH+1)'(b);
        return narrow(c_PW'(s));
    endfunction

    function automatic logic signed [WIDTH-1:0] fx_sub(input logic signed [WIDTH-1:0] a,
                                                       input logic signed [WIDTH-1:0] b);
        logic signed [WIDTH:0] s;
        s = (WIDTH+1)'(a) - (WIDTH+1)'(b);
        return narrow(c_PW'(s));
    endfunction

    logic w_en;

    // Stage 1 registers
    logic                    r_v1;
    logic signed [WIDTH-1:0] r_s1, r_b0_1, r_b1_1, r_b2_1, r_disc1, r_d1, r_sq1;
    // Stage 2 registers
    logic                    r_v2;
    logic signed [WIDTH-1:0] r_b0_2, r_m1_2, r_m2_2, r_d2, r_disc2;
    // Stage 3 registers
    logic                    r_v3, r_ex3;
    logic signed [WIDTH-1:0] r_c3, r_p3, r_disc3;
    // Stage 4 registers
    logic                    r_v4;
    logic signed [WIDTH-1:0] r_pv4;

    logic signed [WIDTH-1:0] w_c, w_p, w_dc, w_pv;
    logic                    w_ex;

    // One enable freezes the whole pipe whenever the output is held.
    assign w_en      = !r_v4 || ready_in;
    assign ready_out = w_en;
    assign valid_out = r_v4;
    assign PV        = r_pv4;

    always_comb begin
        w_c  = fx_add(fx_add(r_b0_2, r_m1_2), r_m2_2);
        w_p  = (r_d2 > c_ZERO) ? r_d2 : c_ZERO;
        w_ex = (w_p > w_c) && (w_p > c_ZERO);
        w_dc = fx_mul(r_disc3, r_c3);
        w_pv = r_ex3 ? r_p3 : ((w_dc < c_ZERO) ? c_ZERO : w_dc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1    <= 1'b0;
            r_s1    <= '0;
            r_b0_1  <= '0;
            r_b1_1  <= '0;
            r_b2_1  <= '0;
            r_disc1 <= '0;
            r_d1    <= '0;
            r_sq1   <= '0;
        end else if (w_en) begin
            r_v1 <= valid_in;
            if (valid_in) begin
                r_s1    <= S_t;
                r_b0_1  <= beta[0];
                r_b1_1  <= beta[1];
                r_b2_1  <= beta[2];
                r_disc1 <= disc;
                r_d1    <= fx_sub(strike, S_t);
                r_sq1   <= fx_mul(S_t, S_t);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2    <= 1'b0;
            r_b0_2  <= '0;
            r_m1_2  <= '0;
            r_m2_2  <= '0;
            r_d2    <= '0;
            r_disc2 <= '0;
        end else if (w_en) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_b0_2  <= r_b0_1;
                r_m1_2  <= fx_mul(r_b1_1, r_s1);
                r_m2_2  <= fx_mul(r_b2_1, r_sq1);
                r_d2    <= r_d1;
                r_disc2 <= r_disc1;
            end
        end
    end

    // Ties (P == C) and worthless puts (P == 0) both keep the continuation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v3    <= 1'b0;
            r_ex3   <= 1'b0;
            r_c3    <= '0;
            r_p3    <= '0;
            r_disc3 <= '0;
        end else if (w_en) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_ex3   <= w_ex;
                r_c3    <= w_c;
                r_p3    <= w_p;
                r_disc3 <= r_disc2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v4  <= 1'b0;
            r_pv4 <= '0;
        end else if (w_en) begin
            r_v4 <= r_v3;
            if (r_v3) begin
                r_pv4 <= w_pv;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsm_decision_unit.sv
`default_nettype none
// ============================================================================
// tb_lsm_decision_unit : directed-vector bench for lsm_decision_unit.  Rev 1.0
// ============================================================================
module tb_lsm_decision_unit;
    localparam int W  = 32;
    localparam int NV = 10;
    localparam int NSTREAM = 24;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic valid_in = 1'b0;
    logic ready_in = 1'b1;
    logic ready_out, valid_out;
    logic signed [W-1:0] S_t = '0, strike = '0, disc = '0;
    logic signed [W-1:0] PV;
    logic signed [W-1:0] beta [0:2];

    int n_checks = 0;
    int n_errors = 0;
    int acc, prod, stale, lat;
    logic prev_stall;
    logic [W-1:0] prev_pv;
    // Columns: S, K, b0, b1, b2, disc, expected PV
    logic [W-1:0] vec [NV][7];
    logic [W-1:0] exp_q [$];

    always #5 clk = ~clk;

    lsm_decision_unit #(.WIDTH(32), .QINT(16), .QFRAC(16)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .S_t       (S_t),
        .beta      (beta),
        .strike    (strike),
        .disc      (disc),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .PV        (PV)
    );

    task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input int i);
        S_t     = vec[i][0];
        strike  = vec[i][1];
        beta[0] = vec[i][2];
        beta[1] = vec[i][3];
        beta[2] = vec[i][4];
        disc    = vec[i][5];
    endtask

    task automatic drive_junk();
        S_t     = 32'h7ABC_1234;
        strike  = 32'h8000_0001;
        beta[0] = 32'h1234_5678;
        beta[1] = 32'hDEAD_BEEF;
        beta[2] = 32'h0F0F_0F0F;
        disc    = 32'h7777_7777;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec[0] = '{32'h0001_0000, 32'h0002_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0001_0000, 32'h0001_0000};
        vec[1] = '{32'h0001_0000, 32'h0002_0000, 32'h0002_0000, 32'h0000_0000, 32'h0000_0000, 32'h0001_0000, 32'h0002_0000};
        vec[2] = '{32'h0003_0000, 32'h0002_0000, 32'h0000_8000, 32'h0000_0000, 32'h0000_0000, 32'h0000_8000, 32'h0000_4000};
        vec[3] = '{32'h0003_0000, 32'h0002_0000, 32'hFFFF_0000, 32'h0000_0000, 32'h0000_0000, 32'h0001_0000, 32'h0000_0000};
        vec[4] = '{32'h0001_0000, 32'h0003_0000, 32'h0002_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_8000, 32'h0001_0000};
        vec[5] = '{32'h0002_0000, 32'h0003_0000, 32'h0001_0000, 32'h0001_0000, 32'h0000_8000, 32'h0000_8000, 32'h0002_8000};
        vec[6] = '{32'h0002_0000, 32'h000A_0000, 32'h0001_0000, 32'h0001_0000, 32'h0000_8000, 32'h0000_8000, 32'h0008_0000};
        vec[7] = '{32'h0002_0000, 32'h0001_0000, 32'h0004_0000, 32'hFFFF_0000, 32'h0000_4000, 32'h0000_C000, 32'h0002_4000};
        vec[8] = '{32'h0001_8000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0001_0000, 32'h0000_5555, 32'h0000_BFFF};
`ifdef LSM_DECISION_SAT_EN
        vec[9] = '{32'h0100_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0001_0000, 32'h0001_0000, 32'h7FFF_FFFF};
`else
        vec[9] = '{32'h0100_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000};
`endif
        drive(0);

        repeat (3) @(negedge clk);
        check_val("reset_valid_out", {31'd0, valid_out}, 32'd0);
        check_val("reset_pv", PV, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("reset_ready_out", {31'd0, ready_out}, 32'd1);

        // Directed vectors, one at a time, never stalled.
        for (int i = 0; i < NV; i++) begin
            drive(i);
            valid_in = 1'b1;
            ready_in = 1'b1;
            @(negedge clk);
            valid_in = 1'b0;
            lat = 1;
            while (!valid_out && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            check_val($sformatf("latency_v%0d", i), lat, 32'd4);
            check_val($sformatf("pv_v%0d", i), PV, vec[i][6]);
            @(negedge clk);
        end

        // Random valid plus ~30% backpressure; scoreboard keeps order.
        acc = 0;
        prod = 0;
        prev_stall = 1'b0;
        prev_pv = '0;
        for (int c = 0; c < 600 && (acc < NSTREAM || exp_q.size() != 0); c++) begin
            ready_in = ($urandom_range(0, 99) >= 30);
            #1;
            valid_in = (acc < NSTREAM) && ($urandom_range(0, 99) < 60);
            if (ready_out) drive(acc % NV);
            else drive_junk();
            #1;
            if (prev_stall) begin
                check_val("stall_pv_stable", PV, prev_pv);
                check_val("stall_valid_held", {31'd0, valid_out}, 32'd1);
            end
            if (valid_out && !ready_in)
                check_val("stall_ready_out", {31'd0, ready_out}, 32'd0);
            if (valid_out && ready_in) begin
                if (exp_q.size() == 0) begin
                    check_val("stream_extra_output", 32'd1, 32'd0);
                end else begin
                    check_val("stream_pv", PV, exp_q.pop_front());
                    prod++;
                end
            end
            if (valid_in && ready_out) begin
                exp_q.push_back(vec[acc % NV][6]);
                acc++;
            end
            prev_stall = valid_out && !ready_in;
            prev_pv = PV;
            @(negedge clk);
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        check_val("stream_accepted", acc, NSTREAM);
        check_val("stream_produced", prod, acc);

        // Asynchronous reset with three samples in flight.
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            drive(0);
            valid_in = 1'b1;
            @(negedge clk);
        end
        valid_in = 1'b0;
        @(negedge clk);
        check_val("prereset_valid_out", {31'd0, valid_out}, 32'd1);
        check_val("prereset_pv", PV, 32'h0001_0000);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_reset_valid_out", {31'd0, valid_out}, 32'd0);
        check_val("async_reset_pv", PV, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (valid_out) stale++;
        end
        check_val("no_stale_output", stale, 32'd0);
        check_val("post_reset_ready_out", {31'd0, ready_out}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
